// File: rtl/systolic_ctrl_pkg.sv
// rtl/systolic_ctrl_pkg.sv - shared types and defaults for the systolic array sequencer
// Contents: ctrl_state_e sequencer states, default array geometry, signed data type,
// addr_w() helper giving a minimum-1-bit address width for small counts.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        DONE
    } ctrl_state_e;

    localparam int DEF_ROWS   = 4;
    localparam int DEF_COLS   = 4;
    localparam int DEF_WIDTH  = 16;
    localparam int DEF_VEC_AW = 8;

    typedef logic signed [DEF_WIDTH-1:0] data_t;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// rtl/systolic_ctrl_if.sv - command, buffer and array-edge signals of the sequencer
// master: sequencer side (drives busy/done, buffer addresses, weight strobes, col_in, result strobes)
// slave:  environment side (drives start/reuse_w/num_vec, activation read data)
// Build option SYSTOLIC_CTRL_BIAS_EN adds bias (in) and left_in (out).
interface systolic_ctrl_if #(
    parameter int ROWS   = systolic_pkg::DEF_ROWS,
    parameter int COLS   = systolic_pkg::DEF_COLS,
    parameter int WIDTH  = systolic_pkg::DEF_WIDTH,
    parameter int VEC_AW = systolic_pkg::DEF_VEC_AW
);
    localparam int WAW = systolic_pkg::addr_w(ROWS);

    logic                   start;
    logic                   reuse_w;
    logic [VEC_AW:0]        num_vec;
    logic                   busy;
    logic                   done;
    logic [WAW-1:0]         w_rd_addr;
    logic [ROWS-1:0]        w_row_we;
    logic                   act_rd_en;
    logic [VEC_AW-1:0]      act_rd_addr;
    logic [COLS*WIDTH-1:0]  act_rd_data;
    logic [COLS*WIDTH-1:0]  col_in;
    logic                   res_we;
    logic [VEC_AW-1:0]      res_addr;
`ifdef SYSTOLIC_CTRL_BIAS_EN
    logic [ROWS*WIDTH-1:0]  bias;
    logic [ROWS*WIDTH-1:0]  left_in;
`endif

    modport master (
`ifdef SYSTOLIC_CTRL_BIAS_EN
        input  bias,
        output left_in,
`endif
        input  start, reuse_w, num_vec, act_rd_data,
        output busy, done, w_rd_addr, w_row_we, act_rd_en, act_rd_addr,
        output col_in, res_we, res_addr
    );

    modport slave (
`ifdef SYSTOLIC_CTRL_BIAS_EN
        output bias,
        input  left_in,
`endif
        output start, reuse_w, num_vec, act_rd_data,
        input  busy, done, w_rd_addr, w_row_we, act_rd_en, act_rd_addr,
        input  col_in, res_we, res_addr
    );

endinterface

// File: rtl/systolic_ctrl_skew_line.sv
// rtl/systolic_ctrl_skew_line.sv - DEPTH-register delay line for one array column
// Ports: clk, rst (async active-low clear), din/vin (data + valid in), dout/vout (delayed).
// Data is forced to zero whenever its valid bit is low, so idle columns feed 0 into the array.
module skew_line #(
    parameter int DEPTH = 0,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             vin,
    output logic [WIDTH-1:0] dout,
    output logic             vout
);

    if (DEPTH == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = &{1'b0, clk, rst};
        assign dout = vin ? din : '0;
        assign vout = vin;
    end else begin : g_pipe
        logic [WIDTH-1:0] d_q [DEPTH];
        logic [DEPTH-1:0] v_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
                v_q <= '0;
            end else begin
                d_q[0] <= vin ? din : '0;
                v_q[0] <= vin;
                for (int i = 1; i < DEPTH; i++) begin
                    d_q[i] <= d_q[i-1];
                    v_q[i] <= v_q[i-1];
                end
            end
        end

        assign dout = d_q[DEPTH-1];
        assign vout = v_q[DEPTH-1];
    end

endmodule

// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - sequencer for a ROWS x COLS weight-stationary systolic array
// Ports: clk, rst (async active-low), bus (systolic_ctrl_if.master): job command
// (start/reuse_w/num_vec/busy/done), weight buffer (w_rd_addr, w_row_we), activation buffer
// (act_rd_en/addr/data), skewed array inputs (col_in), result buffer (res_we/res_addr).
// Build option SYSTOLIC_CTRL_BIAS_EN: bias latched at start, driven on left_in for column 0.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int ROWS   = DEF_ROWS,
    parameter int COLS   = DEF_COLS,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int VEC_AW = DEF_VEC_AW
) (
    input  logic            clk,
    input  logic            rst,
    systolic_ctrl_if.master bus
);

    localparam int              WAW       = addr_w(ROWS);
    localparam int              CW        = VEC_AW + 1;
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]   DRAIN_LEN = CW'(COLS + 1);
    localparam logic [WAW-1:0]  LAST_ROW  = WAW'(ROWS - 1);

    ctrl_state_e         state;
    logic [CW-1:0]       nv;
    logic [CW-1:0]       cnt;
    logic                busy_r;
    logic                done_r;
    logic [WAW-1:0]      w_addr_r;
    logic [ROWS-1:0]     w_we_r;
    logic                rd_en_r;
    logic [VEC_AW-1:0]   rd_addr_r;

    logic                start_acc;
    assign start_acc = (state == IDLE) && bus.start;

    // Entering STREAM and entering DRAIN happen from two states each (IDLE/LOAD_W),
    // so both paths set up the read pointer or drain counter identically.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            nv        <= '0;
            cnt       <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            w_addr_r  <= '0;
            w_we_r    <= '0;
            rd_en_r   <= 1'b0;
            rd_addr_r <= '0;
        end else begin
            done_r <= 1'b0;
            w_we_r <= '0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        nv     <= bus.num_vec;
                        busy_r <= 1'b1;
                        if (!bus.reuse_w) begin
                            state    <= LOAD_W;
                            w_addr_r <= '0;
                        end else if (bus.num_vec == '0) begin
                            state <= DRAIN;
                            cnt   <= DRAIN_LEN;
                        end else begin
                            state     <= STREAM;
                            rd_en_r   <= 1'b1;
                            rd_addr_r <= '0;
                            cnt       <= '0;
                        end
                    end
                end
                LOAD_W: begin
                    // Weight buffer answers one cycle later, so the row strobe trails its address.
                    w_we_r <= ROWS'(1) << w_addr_r;
                    if (w_addr_r == LAST_ROW) begin
                        w_addr_r <= '0;
                        if (nv == '0) begin
                            state <= DRAIN;
                            cnt   <= DRAIN_LEN;
                        end else begin
                            state     <= STREAM;
                            rd_en_r   <= 1'b1;
                            rd_addr_r <= '0;
                            cnt       <= '0;
                        end
                    end else begin
                        w_addr_r <= w_addr_r + WAW'(1);
                    end
                end
                STREAM: begin
                    if (cnt + CNT_ONE == nv) begin
                        rd_en_r <= 1'b0;
                        state   <= DRAIN;
                        cnt     <= DRAIN_LEN;
                    end else begin
                        cnt       <= cnt + CNT_ONE;
                        rd_addr_r <= rd_addr_r + VEC_AW'(1);
                    end
                end
                DRAIN: begin
                    // Covers read latency plus COLS skew stages: ends right after the last result.
                    if (cnt == CNT_ONE) begin
                        state  <= DONE;
                        done_r <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read data is valid one cycle after the read enable.
    logic rd_vld;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_vld <= 1'b0;
        else      rd_vld <= rd_en_r;
    end

    logic [COLS*WIDTH-1:0] col_in_w;
    logic [COLS-1:0]       col_vld;

    for (genvar c = 0; c < COLS; c++) begin : g_col
        skew_line #(
            .DEPTH (c),
            .WIDTH (WIDTH)
        ) u_skew (
            .clk  (clk),
            .rst  (rst),
            .din  (bus.act_rd_data[c*WIDTH +: WIDTH]),
            .vin  (rd_vld),
            .dout (col_in_w[c*WIDTH +: WIDTH]),
            .vout (col_vld[c])
        );
    end

    logic unused_vld;
    assign unused_vld = &{1'b0, col_vld};

    // The last column's element lands in its PE register at the end of its valid cycle,
    // so the right-edge psum is ready one cycle later.
    logic              res_we_r;
    logic [VEC_AW-1:0] res_addr_r;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_we_r   <= 1'b0;
            res_addr_r <= '0;
        end else begin
            res_we_r <= col_vld[COLS-1];
            if (start_acc)     res_addr_r <= '0;
            else if (res_we_r) res_addr_r <= res_addr_r + VEC_AW'(1);
        end
    end

`ifdef SYSTOLIC_CTRL_BIAS_EN
    logic [ROWS*WIDTH-1:0] bias_r;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           bias_r <= '0;
        else if (start_acc) bias_r <= bus.bias;
    end
    assign bus.left_in = col_vld[0] ? bias_r : '0;
`endif

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.w_rd_addr   = w_addr_r;
    assign bus.w_row_we    = w_we_r;
    assign bus.act_rd_en   = rd_en_r;
    assign bus.act_rd_addr = rd_addr_r;
    assign bus.col_in      = col_in_w;
    assign bus.res_we      = res_we_r;
    assign bus.res_addr    = res_addr_r;

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb/tb_systolic_ctrl.sv - self-checking bench for systolic_ctrl with a PE-array model
module tb_systolic_ctrl;
    import systolic_pkg::*;

    localparam int ROWS   = DEF_ROWS;
    localparam int COLS   = DEF_COLS;
    localparam int WIDTH  = DEF_WIDTH;
    localparam int VEC_AW = DEF_VEC_AW;
    localparam int NVW    = VEC_AW + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    systolic_ctrl_if bus ();
    systolic_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [COLS*WIDTH-1:0] amem [1<<VEC_AW];
    logic [COLS*WIDTH-1:0] wmem [ROWS];
    data_t                 wref [ROWS][COLS];
`ifdef SYSTOLIC_CTRL_BIAS_EN
    logic [ROWS*WIDTH-1:0] bias_v;
`endif

    function automatic logic [COLS*WIDTH-1:0] vec(input int a, input int b, input int c, input int d);
        return {WIDTH'(d), WIDTH'(c), WIDTH'(b), WIDTH'(a)};
    endfunction

    function automatic logic [ROWS*WIDTH-1:0] ref_mvm(input logic [COLS*WIDTH-1:0] x);
        logic [ROWS*WIDTH-1:0] y;
        y = '0;
        for (int r = 0; r < ROWS; r++) begin
            data_t acc;
`ifdef SYSTOLIC_CTRL_BIAS_EN
            acc = data_t'(bias_v[r*WIDTH +: WIDTH]);
`else
            acc = '0;
`endif
            for (int c = 0; c < COLS; c++) acc = acc + wref[r][c] * data_t'(x[c*WIDTH +: WIDTH]);
            y[r*WIDTH +: WIDTH] = acc;
        end
        return y;
    endfunction

    // Buffers and PE array model
    logic [COLS*WIDTH-1:0] w_rd_data;
    data_t                 wreg [ROWS][COLS];
    data_t                 psum [ROWS][COLS];
    logic [ROWS*WIDTH-1:0] arr_out;
    logic [ROWS*WIDTH-1:0] left0;
`ifdef SYSTOLIC_CTRL_BIAS_EN
    assign left0 = bus.left_in;
`else
    assign left0 = '0;
`endif

    always @(posedge clk) begin
        w_rd_data <= wmem[bus.w_rd_addr];
        if (bus.act_rd_en) bus.act_rd_data <= amem[bus.act_rd_addr];
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (bus.w_row_we[r]) wreg[r][c] <= data_t'(w_rd_data[c*WIDTH +: WIDTH]);
                psum[r][c] <= data_t'(data_t'(bus.col_in[c*WIDTH +: WIDTH]) * wreg[r][c])
                            + ((c == 0) ? data_t'(left0[r*WIDTH +: WIDTH]) : psum[r][(c == 0) ? 0 : c-1]);
            end
        end
    end

    always_comb begin
        arr_out = '0;
        for (int r = 0; r < ROWS; r++) arr_out[r*WIDTH +: WIDTH] = psum[r][COLS-1];
    end

    // Monitor: expected results pushed when a read is issued, array outputs recorded at res_we
    typedef struct {
        int                    cyc;
        int                    addr;
        logic [ROWS*WIDTH-1:0] y;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  wwe_cyc[$];
    int  wwe_val[$];
    int  done_cyc[$];

    always @(negedge clk) begin
        ev_t ev;
        if (rst) begin
            if (bus.act_rd_en) begin
                ev.cyc = cyc; ev.addr = int'(bus.act_rd_addr);
                ev.y = ref_mvm(amem[bus.act_rd_addr]);
                exp_q.push_back(ev);
            end
            if (bus.res_we) begin
                ev.cyc = cyc; ev.addr = int'(bus.res_addr); ev.y = arr_out;
                obs_q.push_back(ev);
            end
            if (bus.w_row_we != '0) begin
                wwe_cyc.push_back(cyc);
                wwe_val.push_back(int'(bus.w_row_we));
            end
            if (bus.done) done_cyc.push_back(cyc);
        end
    end

    task automatic clear_q();
        exp_q.delete(); obs_q.delete(); wwe_cyc.delete(); wwe_val.delete(); done_cyc.delete();
    endtask

    task automatic pulse_start(input bit rw, input int nv, output int s);
        bus.start = 1'b1; bus.reuse_w = rw; bus.num_vec = NVW'(nv);
        s = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.done) begin ok = 1'b1; break; end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [255:0] outs;
        int s;
        bit ok;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.start = 1'($urandom); bus.reuse_w = 1'($urandom); bus.num_vec = NVW'($urandom);
`ifdef SYSTOLIC_CTRL_BIAS_EN
            bus.bias = {$urandom, $urandom};
`endif
            @(negedge clk);
            outs = '0;
            outs = {bus.busy, bus.done, bus.w_row_we, bus.act_rd_en, bus.res_we,
                    bus.w_rd_addr, bus.act_rd_addr, bus.res_addr, bus.col_in};
`ifdef SYSTOLIC_CTRL_BIAS_EN
            outs = outs | 256'(bus.left_in);
`endif
            checks++;
            if (outs !== '0) begin
                errors++; $display("FAIL reset_outputs[%0d]: got %h expected 0", i, outs);
            end
        end
        bus.start = 1'b0;
`ifdef SYSTOLIC_CTRL_BIAS_EN
        bias_v = '0; bus.bias = bias_v;
`endif
        rst = 1'b1;
        @(negedge clk);
        clear_q();
        pulse_start(1'b0, 2, s);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL reset_busy_after_start: got %b expected 1", bus.busy); end
        wait_done(ok);
        checks++;
        if (!ok || done_cyc.size() != 1 || done_cyc[0] != s + 12) begin
            errors++; $display("FAIL reset_job_done: got %0d dones (ok=%b) expected 1 at C12", done_cyc.size(), ok);
        end
        checks++;
        if (obs_q.size() != 2) begin errors++; $display("FAIL reset_job_results: got %0d expected 2", obs_q.size()); end
    endtask

    task automatic test_full_job();
        int s, i;
        bit ok;
        ev_t o, e;
        clear_q();
        amem[0] = vec(1, 2, 3, 4); amem[1] = vec(5, 6, 7, 8); amem[2] = vec(-1, 0, 2, 9);
        pulse_start(1'b0, 3, s);
        wait_done(ok);
        checks++;
        if (!ok || done_cyc.size() != 1 || done_cyc[0] != s + 13) begin
            errors++; $display("FAIL full_done: got %0d dones (ok=%b) expected 1 at C13", done_cyc.size(), ok);
        end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL full_busy_c14: got %b expected 0", bus.busy); end
        checks++;
        if (wwe_cyc.size() != ROWS) begin errors++; $display("FAIL full_wwe_count: got %0d expected %0d", wwe_cyc.size(), ROWS); end
        for (int r = 0; r < wwe_cyc.size(); r++) begin
            checks++;
            if (wwe_cyc[r] != s + 2 + r || wwe_val[r] != (1 << r)) begin
                errors++; $display("FAIL full_wwe[%0d]: got C%0d %h expected C%0d %h", r, wwe_cyc[r] - s, wwe_val[r], 2 + r, 1 << r);
            end
        end
        checks++;
        if (obs_q.size() != 3 || exp_q.size() != 3) begin
            errors++; $display("FAIL full_counts: got res=%0d rd=%0d expected 3", obs_q.size(), exp_q.size());
        end
        i = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (o.y !== e.y) begin errors++; $display("FAIL full_data[%0d]: got %h expected %h", i, o.y, e.y); end
            checks++;
            if (o.cyc != s + 10 + i || o.addr != i) begin
                errors++; $display("FAIL full_res_timing[%0d]: got C%0d addr %0d expected C%0d addr %0d", i, o.cyc - s, o.addr, 10 + i, i);
            end
            checks++;
            if (e.cyc != s + 5 + i || e.addr != i) begin
                errors++; $display("FAIL full_rd_timing[%0d]: got C%0d addr %0d expected C%0d addr %0d", i, e.cyc - s, e.addr, 5 + i, i);
            end
            i++;
        end
    endtask

    task automatic test_reuse();
        int s;
        bit ok;
        ev_t o, e;
        clear_q();
        amem[0] = vec(3, -2, 5, 7);
        pulse_start(1'b1, 1, s);
        wait_done(ok);
        checks++;
        if (!ok || done_cyc.size() != 1 || done_cyc[0] != s + 7) begin
            errors++; $display("FAIL reuse_done: got %0d dones (ok=%b) expected 1 at C7", done_cyc.size(), ok);
        end
        checks++;
        if (wwe_cyc.size() != 0) begin errors++; $display("FAIL reuse_no_wwe: got %0d expected 0", wwe_cyc.size()); end
        checks++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            errors++; $display("FAIL reuse_counts: got res=%0d rd=%0d expected 1", obs_q.size(), exp_q.size());
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (e.cyc != s + 1 || o.cyc != s + 6) begin
                errors++; $display("FAIL reuse_timing: got rd C%0d res C%0d expected rd C1 res C6", e.cyc - s, o.cyc - s);
            end
            checks++;
            if (o.y !== e.y) begin errors++; $display("FAIL reuse_data: got %h expected %h", o.y, e.y); end
        end
    endtask

    task automatic test_zero_and_busy_start();
        int s;
        bit ok;
        clear_q();
        pulse_start(1'b1, 0, s);
        repeat (2) @(negedge clk);
        bus.start = 1'b1; bus.reuse_w = 1'b0; bus.num_vec = NVW'(3);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok || done_cyc.size() == 0 || done_cyc[0] != s + 6) begin
            errors++; $display("FAIL zero_done_c6: got %0d dones (ok=%b) expected done at C6", done_cyc.size(), ok);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (done_cyc.size() != 1) begin errors++; $display("FAIL zero_single_done: got %0d expected 1", done_cyc.size()); end
        checks++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            errors++; $display("FAIL zero_no_traffic: got rd=%0d res=%0d expected 0", exp_q.size(), obs_q.size());
        end
    endtask

    task automatic test_mid_reset();
        int s, i;
        bit ok;
        logic [255:0] outs;
        ev_t o, e;
        clear_q();
        amem[0] = vec(1, 2, 3, 4); amem[1] = vec(5, 6, 7, 8); amem[2] = vec(-1, 0, 2, 9);
        pulse_start(1'b0, 3, s);
        repeat (5) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        outs = '0;
        outs = {bus.busy, bus.done, bus.w_row_we, bus.act_rd_en, bus.res_we,
                bus.w_rd_addr, bus.act_rd_addr, bus.res_addr, bus.col_in};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL midrst_outputs: got %h expected 0", outs); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        clear_q();
        amem[0] = vec(7, -3, 0, 1); amem[1] = vec(2, 2, 2, 2);
        pulse_start(1'b0, 2, s);
        wait_done(ok);
        checks++;
        if (!ok || done_cyc.size() != 1 || done_cyc[0] != s + 12) begin
            errors++; $display("FAIL midrst_done: got %0d dones (ok=%b) expected 1 at C12", done_cyc.size(), ok);
        end
        checks++;
        if (obs_q.size() != 2 || exp_q.size() != 2) begin
            errors++; $display("FAIL midrst_counts: got res=%0d rd=%0d expected 2", obs_q.size(), exp_q.size());
        end
        i = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (o.y !== e.y || o.addr != i || o.cyc != s + 10 + i) begin
                errors++; $display("FAIL midrst_res[%0d]: got %h addr %0d C%0d expected %h addr %0d C%0d",
                                   i, o.y, o.addr, o.cyc - s, e.y, i, 10 + i);
            end
            i++;
        end
    endtask

    task automatic test_bias();
        int s;
        bit ok;
        ev_t o, e;
        logic [ROWS*WIDTH-1:0] want;
        clear_q();
`ifdef SYSTOLIC_CTRL_BIAS_EN
        bias_v = vec(10, 20, 30, 40); bus.bias = bias_v;
        want = vec(11, 22, 33, 44);
`else
        want = vec(1, 2, 3, 4);
`endif
        amem[0] = vec(1, 2, 3, 4);
        pulse_start(1'b1, 1, s);
        wait_done(ok);
        checks++;
        if (!ok || obs_q.size() != 1 || exp_q.size() != 1) begin
            errors++; $display("FAIL bias_counts: got res=%0d rd=%0d (ok=%b) expected 1", obs_q.size(), exp_q.size(), ok);
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (o.y !== want) begin errors++; $display("FAIL bias_result: got %h expected %h", o.y, want); end
            checks++;
            if (e.y !== want) begin errors++; $display("FAIL bias_model: got %h expected %h", e.y, want); end
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.reuse_w = 1'b0; bus.num_vec = '0; bus.act_rd_data = '0;
`ifdef SYSTOLIC_CTRL_BIAS_EN
        bias_v = '0; bus.bias = '0;
`endif
        for (int r = 0; r < ROWS; r++) begin
            wmem[r] = '0;
            for (int c = 0; c < COLS; c++) begin
                wref[r][c] = (r == c) ? data_t'(1) : data_t'(0);
                if (r == c) wmem[r][c*WIDTH +: WIDTH] = WIDTH'(1);
            end
        end
        for (int a = 0; a < (1 << VEC_AW); a++) amem[a] = vec(a, a + 1, -a, 2 * a);
        test_reset();
        test_full_job();
        test_reuse();
        test_zero_and_busy_start();
        test_mid_reset();
        test_bias();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
- Sequencer for a ROWS x COLS weight-stationary systolic array of multiply-accumulate PEs. Each PE computes psum_out <= in_up*weight + in_left. Activations broadcast down each column combinationally; partial sums move one register per column to the right.
- The block loads weight rows, streams activation vectors from a synchronous memory with a per-column skew, and emits result write strobes aligned to the array's right-edge outputs.
- It sits between the top-level command interface, the weight/activation buffers and the result buffer.

Parameters:
ROWS, 4, array rows (PE rows, result vector length)
COLS, 4, array columns (activation vector length)
WIDTH, 16, signed data width of activations, weights and bias
VEC_AW, 8, activation/result address width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  single-cycle job request; sampled only in IDLE
reuse_w  in  1  sampled with start; 1 = skip weight load
num_vec  in  VEC_AW+1  number of activation vectors in the job
busy  out  1  job in progress
done  out  1  one-cycle pulse at job end
w_rd_addr  out  $clog2(ROWS)  weight-buffer row address
w_row_we  out  ROWS  one-hot write enable into the array weight registers
act_rd_en  out  1  activation-buffer read enable
act_rd_addr  out  VEC_AW  activation vector index
act_rd_data  in  COLS*WIDTH  read data, valid 1 cycle after act_rd_en
col_in  out  COLS*WIDTH  skewed activations to the array's in_up (column c in slice c)
res_we  out  1  result-buffer write strobe
res_addr  out  VEC_AW  result vector index

Behaviour:
- Reset (async, any state):
  - FSM goes to IDLE.
  - busy, done, w_row_we, act_rd_en, res_we are 0.
  - All addresses are 0.
  - All skew registers are 0, so col_in is 0.
- FSM states: IDLE -> LOAD_W -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start=1 latches num_vec and reuse_w.
  - Next state is STREAM if reuse_w=1, otherwise LOAD_W.
- LOAD_W (ROWS cycles):
  - w_rd_addr = 0..ROWS-1, one per cycle.
  - w_row_we[r] pulses 1 cycle after address r (weight buffer has 1-cycle read latency).
  - Then go to STREAM.
- STREAM (num_vec cycles):
  - act_rd_en=1, act_rd_addr = k = 0..num_vec-1.
  - num_vec=0: no reads; go straight to DRAIN, which then produces no res_we.
- Skew:
  - Column c receives the element x_c of vector k during cycle T+1+k+c, where T is the cycle act_rd_addr=0 is issued.
  - Column 0 is act_rd_data registered zero times; column c is delayed by c registers.
  - A slice is 0 whenever it carries no valid element.
- Results:
  - res_we=1 with res_addr=k during cycle T+1+k+COLS. Latency from address issue to result is COLS+1.
  - Exactly num_vec strobes per job, on consecutive cycles.
- DRAIN:
  - Waits until the last res_we has been issued; a down-counter is loaded with COLS+1.
  - Then go to DONE.
- DONE: done=1 for 1 cycle, then return to IDLE.
- busy=1 from the cycle after start is accepted through the DONE cycle inclusive.
- start while busy is ignored. Back-to-back: start can be accepted in the cycle after DONE.
- Weights must stay constant while the array holds live data. No w_row_we may assert after STREAM begins in the same job, except the final LOAD_W strobe, which may overlap the first STREAM cycle.
- The array's column-0 in_left is 0 (see the optional feature).
- Counters use widths that avoid wrap: num_vec up to 2^VEC_AW.

Optional Feature:
- Macro: SYSTOLIC_CTRL_BIAS_EN.
- Defined:
  - Adds input bias [ROWS*WIDTH], latched at job start.
  - Adds output left_in [ROWS*WIDTH] driving column-0 in_left.
  - left_in = latched bias whenever column 0 carries a valid element, otherwise 0.
  - Each result is W*x + bias, truncated to WIDTH.
- Undefined: no bias or left_in ports; the array top ties column-0 in_left to 0.

Decomposition:
- Package systolic_pkg:
  - ctrl_state_e enum (IDLE, LOAD_W, STREAM, DRAIN, DONE).
  - Default ROWS/COLS/WIDTH/VEC_AW localparams.
  - Signed data typedef data_t [WIDTH-1:0].
- Sub-module skew_line:
  - Parameter DEPTH, plus a valid bit.
  - Instantiated per column with DEPTH=c.
  - Zeroes data when invalid; async active-low clear.

Test Plan:
- Reset: hold rst=0 with random inputs. All outputs are 0. Release, pulse start with num_vec=2: FSM leaves IDLE cleanly.
- Full job, ROWS=COLS=4:
  - start at C0, reuse_w=0, num_vec=3, W=identity, x0=[1,2,3,4], x1=[5,6,7,8], x2=[-1,0,2,9], with a reference PE-array model.
  - w_row_we in C2..C5; act_rd_addr 0,1,2 in C5..C7.
  - res_we in C10, C11, C12 with results x0, x1, x2.
  - done in C13; busy low in C14.
- reuse_w=1, num_vec=1: no w_row_we; act_rd_addr 0 in C1; res_we in C6; done in C7.
- num_vec=0 and start during busy: no act_rd_en and no res_we; done at C6. A start pulse at C3 is ignored, giving exactly one done.
- rst asserted mid-STREAM (C6 of the full job): all outputs and col_in are 0 immediately. A fresh job afterward produces correct results.
- SYSTOLIC_CTRL_BIAS_EN: bias=[10,20,30,40], W=identity, x=[1,2,3,4] -> result [11,22,33,44]. Without the macro, the same stimulus gives [1,2,3,4].
